cpu_clk_ctrl: RTL

//  Parametrised CPU clock-enable controller; sits between board top and cpu_main, drives clk_en_i.

---
 rtl/cpu_clk_ctrl_pkg.sv | 20 ++
 rtl/cpu_debounce.sv | 52 +++++
 rtl/cpu_clk_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types for the CPU clock-enable controller.
//   clk_mode_t : operating mode selected by mode_i
//   LED_CNT_W  : width of the free-running halt-LED dimming counter
//   is_run()   : true for the two free-running divider modes
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN_FIXED = 2'd0,
    RUN_PROG  = 2'd1,
    STEP      = 2'd2,
    STOP      = 2'd3
  } clk_mode_t;

  localparam int LED_CNT_W = 8;

  function automatic logic is_run(input clk_mode_t m);
    return (m == RUN_FIXED) || (m == RUN_PROG);
  endfunction

endpackage

// File: rtl/cpu_debounce.sv
// Step-button conditioner: 2-FF synchroniser followed by a stability counter.
//   clk      : system clock
//   reset_i  : synchronous active-high reset (button treated as released)
//   raw_i    : raw asynchronous button, active-high
//   stable_o : debounced button level
//   rise_o   : high for one cycle after stable_o goes 0->1
module cpu_debounce #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic reset_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  stable_q;
  logic                  stable_d_q;
  logic [DEBOUNCE_W-1:0] dcnt_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= 1'b0;
      stable_d_q <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      stable_d_q <= stable_q;
      // The synchronised level must disagree with the accepted level for a
      // full counter span before it is accepted; any agreement restarts it.
      if (sync2_q != stable_q) begin
        if (&dcnt_q) begin
          stable_q <= sync2_q;
          dcnt_q   <= '0;
        end else begin
          dcnt_q <= dcnt_q + DEBOUNCE_W'(1);
        end
      end else begin
        dcnt_q <= '0;
      end
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~stable_d_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: produces a single-cycle clk_en_o pulse train
// for cpu_main from a fixed or runtime-programmable divider, from a debounced
// single-step button, or nothing at all (STOP). halt_i gates every pulse.
//   clk           : system clock (only clock)
//   reset_i       : synchronous active-high reset
//   mode_i        : clk_mode_t selection
//   div_i         : new period-1 for RUN_PROG
//   div_load_i    : one-cycle strobe capturing div_i as a pending divisor
//   step_btn_i    : raw step button, active-high
//   halt_i        : CPU halt; suppresses enables while high
//   clk_en_o      : registered CPU clock enable
//   halted_o      : registered copy of halt_i
//   led_beat_n_o  : active-low heartbeat LED
//   led_halt_n_o  : active-low, dimmed halt LED
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int          DIV_W       = 19,
  parameter int unsigned DEFAULT_DIV = 2**19 - 1,
  parameter int          DEBOUNCE_W  = 16,
  parameter int          LED_W       = 4
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  input  logic             step_btn_i,
  input  logic             halt_i,
  output logic             clk_en_o,
  output logic             halted_o,
  output logic             led_beat_n_o,
  output logic             led_halt_n_o
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  clk_mode_t            mode_in;
  clk_mode_t            mode_q;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_pend_q, period;
  logic                 pend_v_q;
  logic                 clk_en_q, clk_en_d;
  logic                 halted_q;
  logic [LED_CNT_W-1:0] led_cnt_q;
  logic                 led_beat_n_q, led_halt_n_q;
  logic                 run_mode, mode_chg, wrap, beat_on;
  logic                 stable, rise;

  assign mode_in = clk_mode_t'(mode_i);

  cpu_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_debounce (
    .clk      (clk),
    .reset_i  (reset_i),
    .raw_i    (step_btn_i),
    .stable_o (stable),
    .rise_o   (rise)
  );

  always_comb begin
    period   = (mode_q == RUN_FIXED) ? DEF_DIV : div_q;
    run_mode = is_run(mode_q);
    mode_chg = (mode_in != mode_q);
    // A mode change restarts the count, so it can never coincide with a wrap.
    wrap     = run_mode && !mode_chg && (cnt_q == period);
    if (run_mode) begin
      beat_on = !halted_q && (cnt_q[DIV_W-1 -: LED_W] == '0);
    end else begin
      beat_on = (mode_q == STEP) && stable;
    end
  end

  // Next count / enable. STEP and STOP hold the counter at zero.
  always_comb begin
    cnt_d    = '0;
    clk_en_d = 1'b0;
    if (!mode_chg) begin
      case (mode_q)
        RUN_FIXED, RUN_PROG: begin
          if (wrap) clk_en_d = !halt_i;
          else      cnt_d    = cnt_q + DIV_W'(1);
        end
        STEP:    clk_en_d = rise && !halt_i;
        default: clk_en_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cnt_q        <= '0;
      div_q        <= DEF_DIV;
      div_pend_q   <= DEF_DIV;
      pend_v_q     <= 1'b0;
      clk_en_q     <= 1'b0;
      halted_q     <= 1'b0;
      mode_q       <= mode_in;
      led_cnt_q    <= '0;
      led_beat_n_q <= 1'b1;
      led_halt_n_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      clk_en_q  <= clk_en_d;
      mode_q    <= mode_in;
      halted_q  <= halt_i;
      led_cnt_q <= led_cnt_q + LED_CNT_W'(1);
      // The pending divisor only takes over at a period boundary so a running
      // period is never cut short; outside RUN_* there is no period to protect.
      if (pend_v_q && (wrap || !run_mode)) begin
        div_q    <= div_pend_q;
        pend_v_q <= 1'b0;
      end
      // A load on the wrap cycle becomes the next pending value (wins pend_v).
      if (div_load_i) begin
        div_pend_q <= div_i;
        pend_v_q   <= 1'b1;
      end
      led_beat_n_q <= !beat_on;
      led_halt_n_q <= !(halted_q && (led_cnt_q == '0));
    end
  end

  assign clk_en_o     = clk_en_q;
  assign halted_o     = halted_q;
  assign led_beat_n_o = led_beat_n_q;
  assign led_halt_n_o = led_halt_n_q;

endmodule
